// File: rtl/spwm_pkg.sv
// spwm_pkg: shared constants and FSM state type for the three-phase
// sine LUT scheduler (table size, widths, phase offsets, idle level).
package spwm_pkg;

    localparam int unsigned SIZE = 407;
    localparam int unsigned DW   = 12;
    localparam int unsigned AW   = 9;

    localparam logic [AW-1:0] OFF_B    = 9'd136;
    localparam logic [AW-1:0] OFF_C    = 9'd271;
    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);
    localparam logic [DW-1:0] MID      = 12'd819;
    localparam logic [15:0]   MIN_DIV  = 16'd5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_A,
        RD_B,
        RD_C,
        UPDATE
    } state_t;

endpackage

// File: rtl/spwm_lut_sched_if.sv
// spwm_lut_sched_if: ROM read bus (rd_en/addr/data) and the three-phase
// sample bus (sine_a/b/c, samples_valid, sync_out) of the scheduler.
interface spwm_lut_sched_if;
    import spwm_pkg::*;

    logic          lut_rd_en;
    logic [AW-1:0] lut_addr;
    logic [DW-1:0] lut_data;
    logic [DW-1:0] sine_a;
    logic [DW-1:0] sine_b;
    logic [DW-1:0] sine_c;
    logic          samples_valid;
    logic          sync_out;

    modport master (
        output lut_rd_en, lut_addr,
        input  lut_data,
        output sine_a, sine_b, sine_c,
        output samples_valid, sync_out
    );

    modport slave (
        input  lut_rd_en, lut_addr,
        output lut_data,
        input  sine_a, sine_b, sine_c,
        input  samples_valid, sync_out
    );

endinterface

// File: rtl/spwm_idx_wrap.sv
// spwm_idx_wrap: modular add of a table index and a phase offset.
// Ports: base_i, off_i (both < SIZE) -> addr_o = (base_i + off_i) mod SIZE.
module spwm_idx_wrap
    import spwm_pkg::*;
(
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] off_i,
    output logic [AW-1:0] addr_o
);

    localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);

    logic [AW:0] sum;

    // Both operands are below SIZE, so one conditional subtract suffices.
    always_comb begin
        sum = {1'b0, base_i} + {1'b0, off_i};
        if (sum >= SIZE_W) begin
            addr_o = AW'(sum - SIZE_W);
        end else begin
            addr_o = AW'(sum);
        end
    end

endmodule

// File: rtl/spwm_lut_sched.sv
// spwm_lut_sched: shares one sine ROM across phases A/B/C. Each sample
// tick reads base, base+OFF_B, base+OFF_C and publishes all three at once.
// Ports: clk_in, rst_in (sync, active high), enable, step_div (clocks per
// step), busy (read sequence in flight), bus (ROM + sample interface).
module spwm_lut_sched
    import spwm_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable,
    input  logic [15:0]       step_div,
    output logic              busy,
    spwm_lut_sched_if.master  bus
);

    state_t        state_q;
    logic [AW-1:0] base_idx_q;
    logic [15:0]   tick_cnt_q;
    logic [15:0]   tick_cnt_d;
    logic [15:0]   lim;
    logic          tick;

    logic          rd_en_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] shadow_a_q;
    logic [DW-1:0] shadow_b_q;
    logic [DW-1:0] sine_a_q;
    logic [DW-1:0] sine_b_q;
    logic [DW-1:0] sine_c_q;
    logic          valid_q;
    logic          sync_q;
    logic          busy_q;

    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_c;

    spwm_idx_wrap u_wrap_b (
        .base_i (base_idx_q),
        .off_i  (OFF_B),
        .addr_o (addr_b)
    );

    spwm_idx_wrap u_wrap_c (
        .base_i (base_idx_q),
        .off_i  (OFF_C),
        .addr_o (addr_c)
    );

    // '>=' so a lowered step_div below the running count ticks at once.
    always_comb begin
        lim  = (step_div < MIN_DIV) ? MIN_DIV : step_div;
        tick = enable && (tick_cnt_q >= lim - 16'd1);
        if (!enable || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            base_idx_q <= '0;
            tick_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            shadow_a_q <= MID;
            shadow_b_q <= MID;
            sine_a_q   <= MID;
            sine_b_q   <= MID;
            sine_c_q   <= MID;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        state_q <= RD_A;
                        rd_en_q <= 1'b1;
                        addr_q  <= base_idx_q;
                        busy_q  <= 1'b1;
                    end
                end
                RD_A: begin
                    state_q <= RD_B;
                    addr_q  <= addr_b;
                end
                RD_B: begin
                    state_q    <= RD_C;
                    shadow_a_q <= bus.lut_data;
                    addr_q     <= addr_c;
                end
                RD_C: begin
                    state_q    <= UPDATE;
                    shadow_b_q <= bus.lut_data;
                    rd_en_q    <= 1'b0;
                end
                UPDATE: begin
                    sine_a_q <= shadow_a_q;
                    sine_b_q <= shadow_b_q;
                    sine_c_q <= bus.lut_data;
                    valid_q  <= 1'b1;
                    sync_q   <= (base_idx_q == '0);
                    busy_q   <= 1'b0;
                    if (base_idx_q == LAST_IDX) begin
                        base_idx_q <= '0;
                    end else begin
                        base_idx_q <= base_idx_q + 1'b1;
                    end
                    state_q <= enable ? WAIT : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.lut_rd_en     = rd_en_q;
    assign bus.lut_addr      = addr_q;
    assign bus.sine_a        = sine_a_q;
    assign bus.sine_b        = sine_b_q;
    assign bus.sine_c        = sine_c_q;
    assign bus.samples_valid = valid_q;
    assign bus.sync_out      = sync_q;
    assign busy              = busy_q;

endmodule
